// File: rtl/sha256_cfu_pkg.sv
// sha256_cfu_pkg: shared types, constants and bit helpers for the SHA-256 CFU scheduler.
package sha256_cfu_pkg;
   localparam int FN_W     = 3;
   localparam int ID_W_DEF = 4;
   typedef enum logic [FN_W-1:0] {FN_SIG0, FN_SIG1, FN_SUM0, FN_SUM1, FN_WPART} func_t;
   typedef struct packed {
      logic [ID_W_DEF-1:0] id;
      logic [31:0]         data;
      logic                err;
   } resp_entry_t;
   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
      return (x >> n) | (x << (6'd32 - {1'b0, n}));
   endfunction
   function automatic logic [31:0] shr32(input logic [31:0] x, input logic [4:0] n);
      return x >> n;
   endfunction
endpackage

// File: rtl/sha256_sigma_unit.sv
// sha256_sigma_unit: combinational SHA-256 sigma/Sigma evaluation selected by func.
module sha256_sigma_unit
   import sha256_cfu_pkg::*;
(
   input  logic [FN_W-1:0] func_i,
   input  logic [31:0]     d0_i,
   input  logic [31:0]     d1_i,
   output logic [31:0]     data_o,
   output logic            err_o
);
   logic [31:0] sig0, sig1, sum0, sum1;
   assign sig0 = ror32(d0_i, 5'd7) ^ ror32(d0_i, 5'd18) ^ shr32(d0_i, 5'd3);
   assign sig1 = ror32(d0_i, 5'd17) ^ ror32(d0_i, 5'd19) ^ shr32(d0_i, 5'd10);
   assign sum0 = ror32(d0_i, 5'd2) ^ ror32(d0_i, 5'd13) ^ ror32(d0_i, 5'd22);
   assign sum1 = ror32(d0_i, 5'd6) ^ ror32(d0_i, 5'd11) ^ ror32(d0_i, 5'd25);
   always_comb begin
      data_o = 32'h0;
      err_o  = 1'b0;
      case (func_i)
         FN_SIG0:  data_o = sig0;
         FN_SIG1:  data_o = sig1;
         FN_SUM0:  data_o = sum0;
         FN_SUM1:  data_o = sum1;
         FN_WPART: data_o = sig1 + d1_i;
         default:  err_o  = 1'b1;
      endcase
   end
endmodule

// File: rtl/sha256_cfu_sched.sv
// sha256_cfu_sched: accepts tagged sigma requests, computes in one cycle and returns
// results in order through a small response FIFO.
module sha256_cfu_sched
   import sha256_cfu_pkg::*;
#(
   parameter int ID_W  = ID_W_DEF,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [ID_W-1:0] req_id,
   input  logic [FN_W-1:0] req_func,
   input  logic [31:0]     req_data0,
   input  logic [31:0]     req_data1,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [ID_W-1:0] resp_id,
   output logic [31:0]     resp_data,
   output logic            resp_err,
   output logic [31:0]     ops_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic            err;
   } entry_t;
   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   ops_q;
   logic [31:0]   res;
   logic          res_err, push, pop;
   sha256_sigma_unit u_sigma (
      .func_i(req_func),
      .d0_i  (req_data0),
      .d1_i  (req_data1),
      .data_o(res),
      .err_o (res_err)
   );
   // ready depends only on registered occupancy; a same-cycle pop never frees a slot early
   assign req_ready  = cnt_q != FULL;
   assign resp_valid = cnt_q != '0;
   assign push       = req_valid && req_ready;
   assign pop        = resp_valid && resp_ready;
   assign cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   assign resp_id    = mem_q[rd_q].id;
   assign resp_data  = mem_q[rd_q].data;
   assign resp_err   = mem_q[rd_q].err;
   assign ops_count  = ops_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ops_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= '{id: req_id, data: res, err: res_err};
            wr_q        <= wr_q + 1'b1;
            ops_q       <= ops_q + 32'd1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end
endmodule
